// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin share of one ALU between two requesters (optional grant counters: ALU_ARB_STATS_EN)
module alu_share_arbiter #(
   parameter int DW = 32
`ifdef ALU_ARB_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [DW-1:0] req0_a,
   input  logic [DW-1:0] req0_b,
   input  logic [2:0]    req0_op,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [DW-1:0] req1_a,
   input  logic [DW-1:0] req1_b,
   input  logic [2:0]    req1_op,
   output logic [DW-1:0] alu_srca,
   output logic [DW-1:0] alu_srcb,
   output logic [2:0]    alu_ctrl,
   input  logic [DW-1:0] alu_result,
   input  logic          alu_zero,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_id,
   output logic [DW-1:0] rsp_result,
   output logic          rsp_zero,
   output logic          rsp_err
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t        state, state_nxt;
   logic          ptr;      // preferred requester for the next grant
   logic          accept;
   logic          gnt_id;
   logic [DW-1:0] lat_a, lat_b;
   logic [2:0]    lat_op;
   logic          lat_id;

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // next state, grant selection and ready strobes; ready is held low during reset
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      gnt_id     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         S_IDLE: begin
            if (!reset && (req0_valid || req1_valid)) begin
               accept     = 1'b1;
               gnt_id     = ptr ? req1_valid : ~req0_valid;
               req0_ready = ~gnt_id;
               req1_ready = gnt_id;
               state_nxt  = S_EXEC;
            end
         end
         S_EXEC:  state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // operand capture on accept, response capture at the end of the ALU cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr        <= 1'b0;
         lat_a      <= '0;
         lat_b      <= '0;
         lat_op     <= '0;
         lat_id     <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         if (accept) begin
            lat_a  <= gnt_id ? req1_a  : req0_a;
            lat_b  <= gnt_id ? req1_b  : req0_b;
            lat_op <= gnt_id ? req1_op : req0_op;
            lat_id <= gnt_id;
            ptr    <= ~gnt_id;
         end
         if (state == S_EXEC) begin
            rsp_id <= lat_id;
            // unsupported op codes: ALU outputs ignored, error flagged
            if (lat_op[2]) begin
               rsp_result <= '0;
               rsp_zero   <= 1'b0;
               rsp_err    <= 1'b1;
            end else begin
               rsp_result <= alu_result;
               rsp_zero   <= alu_zero;
               rsp_err    <= 1'b0;
            end
         end
      end
   end

`ifdef ALU_ARB_STATS_EN
   // saturating per-requester grant counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_cnt0 <= '0;
         gnt_cnt1 <= '0;
      end else if (accept) begin
         if (!gnt_id && gnt_cnt0 != {CNT_W{1'b1}}) gnt_cnt0 <= gnt_cnt0 + 1'b1;
         if (gnt_id  && gnt_cnt1 != {CNT_W{1'b1}}) gnt_cnt1 <= gnt_cnt1 + 1'b1;
      end
   end
`endif

   assign alu_srca  = lat_a;
   assign alu_srcb  = lat_b;
   assign alu_ctrl  = lat_op;
   assign rsp_valid = (state == S_RESP);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]  req0_op, req1_op;
   logic [31:0] alu_srca, alu_srcb, alu_result;
   logic [2:0]  alu_ctrl;
   logic        alu_zero;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
   logic [31:0] rsp_result;
`ifdef ALU_ARB_STATS_EN
   logic [1:0]  gnt_cnt0, gnt_cnt1;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // ALU model: 0 AND, 1 OR, 2 ADD, 3 SUB; other codes return garbage with zero set
   always_comb begin
      case (alu_ctrl)
         3'd0:    alu_result = alu_srca & alu_srcb;
         3'd1:    alu_result = alu_srca | alu_srcb;
         3'd2:    alu_result = alu_srca + alu_srcb;
         3'd3:    alu_result = alu_srca - alu_srcb;
         default: alu_result = 32'hFFFF_FFFF;
      endcase
      alu_zero = (alu_result == 32'd0) || alu_ctrl[2];
   end

   alu_share_arbiter #(
      .DW(32)
`ifdef ALU_ARB_STATS_EN
      , .CNT_W(2)
`endif
   ) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
`ifdef ALU_ARB_STATS_EN
      , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // present one request alone, confirm the grant, drop valid right after the accepting edge
   task automatic issue(input bit who, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      @(posedge clk); #1;
      if (who) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
      end
      @(negedge clk);
      chk("issue_rdy_granted", who ? req1_ready : req0_ready, 1);
      chk("issue_rdy_other",   who ? req0_ready : req1_ready, 0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   // EXEC cycle then RESP cycle, starting right after the accepting edge
   task automatic expect_rsp(input bit id, input logic [31:0] res, input bit z, input bit e,
                             input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      @(negedge clk);
      chk("exec_rsp_valid", rsp_valid, 0);
      chk("exec_srca", alu_srca, a);
      chk("exec_srcb", alu_srcb, b);
      chk("exec_ctrl", alu_ctrl, op);
      chk("exec_ready", {req0_ready, req1_ready}, 0);
      @(negedge clk);
      chk("resp_valid",  rsp_valid, 1);
      chk("resp_id",     rsp_id, id);
      chk("resp_result", rsp_result, res);
      chk("resp_zero",   rsp_zero, z);
      chk("resp_err",    rsp_err, e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 0; req0_b = 0; req0_op = 0;
      req1_valid = 1'b0; req1_a = 0; req1_b = 0; req1_op = 0;
      @(negedge clk);
      chk("reset_req0_ready", req0_ready, 0);
      chk("reset_rsp_valid",  rsp_valid, 0);
      chk("reset_srca",       alu_srca, 0);
      chk("reset_rsp",        {rsp_result, rsp_id, rsp_zero, rsp_err}, 0);
      @(posedge clk); #1;
      reset = 1'b0; req0_valid = 1'b0;

      // 1: ADD from requester 0
      issue(0, 32'd5, 32'd3, 3'd2);
      expect_rsp(0, 32'd8, 0, 0, 32'd5, 32'd3, 3'd2);
      @(negedge clk);
      chk("t1_handoff_done", rsp_valid, 0);

      // 2: SUB to zero from requester 1
      issue(1, 32'd7, 32'd7, 3'd3);
      expect_rsp(1, 32'd0, 1, 0, 32'd7, 32'd7, 3'd3);

      // 3: both valid continuously from reset -> 0,1,0,1
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      req0_valid = 1'b1; req0_a = 32'hF0; req0_b = 32'h3C; req0_op = 3'd0;
      req1_valid = 1'b1; req1_a = 32'h0F; req1_b = 32'h30; req1_op = 3'd1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t3_req0_ready", req0_ready, (k % 2) == 0);
         chk("t3_req1_ready", req1_ready, (k % 2) == 1);
         @(negedge clk);
         @(negedge clk);
         chk("t3_rsp_id",     rsp_id, k % 2);
         chk("t3_rsp_result", rsp_result, (k % 2) ? 32'h3F : 32'h30);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;

      // 4: unsupported op with stalled consumer
      rsp_ready = 1'b0;
      issue(0, 32'd9, 32'd9, 3'd5);
      expect_rsp(0, 32'd0, 0, 1, 32'd9, 32'd9, 3'd5);
      @(posedge clk); #1;
      req0_valid = 1'b1;
      req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd1; req1_op = 3'd3;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t4_hold_valid",  rsp_valid, 1);
         chk("t4_hold_rsp",    {rsp_result, rsp_zero, rsp_err}, {32'd0, 1'b0, 1'b1});
         chk("t4_hold_ready",  {req0_ready, req1_ready}, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("t4_handoff_valid", rsp_valid, 1);
      chk("t4_handoff_ready", {req0_ready, req1_ready}, 0);
      @(negedge clk);
      chk("t4_idle_valid", rsp_valid, 0);
      chk("t4_idle_grant", {req0_ready, req1_ready}, 2'b01);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      expect_rsp(1, 32'd1, 0, 0, 32'd2, 32'd1, 3'd3);

      // 5: reset during EXEC discards the transaction and the pointer
      issue(0, 32'd1, 32'd1, 3'd2);
      @(negedge clk);
      chk("t5_exec_srca", alu_srca, 1);
      reset = 1'b1;
      #1;
      chk("t5_rst_alu",    {alu_srca, alu_srcb, alu_ctrl}, 0);
      chk("t5_rst_rsp",    {rsp_valid, rsp_result}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("t5_no_rsp_a", rsp_valid, 0);
      @(negedge clk);
      chk("t5_no_rsp_b", rsp_valid, 0);
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd4; req0_op = 3'd3;
      req1_valid = 1'b1;
      @(negedge clk);
      chk("t5_ptr_reset", {req0_ready, req1_ready}, 2'b10);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      expect_rsp(0, 32'd0, 1, 0, 32'd4, 32'd4, 3'd3);

`ifdef ALU_ARB_STATS_EN
      // 6: grant counters with saturation at 2 bits
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("t6_cnt_reset", {gnt_cnt0, gnt_cnt1}, 0);
      for (int k = 0; k < 3; k++) begin
         issue(0, 32'd1, 32'd2, 3'd2);
         expect_rsp(0, 32'd3, 0, 0, 32'd1, 32'd2, 3'd2);
      end
      for (int k = 0; k < 2; k++) begin
         issue(1, 32'd6, 32'd3, 3'd0);
         expect_rsp(1, 32'd2, 0, 0, 32'd6, 32'd3, 3'd0);
      end
      chk("t6_gnt_cnt0", gnt_cnt0, 3);
      chk("t6_gnt_cnt1", gnt_cnt1, 2);
      for (int k = 0; k < 2; k++) begin
         issue(0, 32'd1, 32'd2, 3'd2);
         expect_rsp(0, 32'd3, 0, 0, 32'd1, 32'd2, 3'd2);
      end
      chk("t6_gnt_cnt0_sat", gnt_cnt0, 3);
      chk("t6_gnt_cnt1_hold", gnt_cnt1, 2);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
